// File: rtl/spike_packetizer.sv
// +--------------------------------------------------------------------------+
// | spike_packetizer: round-robin spike arbiter feeding a show-ahead address  |
// | FIFO; merges repeat spikes on pending neurons.  Rev 1.0                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module spike_packetizer #(
  parameter int          NUM_NEURONS = 16,
  parameter logic [11:0] BASE_ADDR   = 12'd1,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic [11:0]            source_address,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic                   fifo_full,
  output logic                   spike_merged
);

  localparam int c_idx_w = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int c_aw    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cw    = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cw-1:0]  c_depth = c_cw'(FIFO_DEPTH);
  localparam logic [c_aw-1:0]  c_last  = c_aw'(FIFO_DEPTH - 1);
  localparam logic [c_idx_w:0] c_num   = (c_idx_w + 1)'(NUM_NEURONS);

  logic [NUM_NEURONS-1:0] r_pending;
  logic [c_idx_w-1:0]     r_rr_ptr;
  logic [11:0]            r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]        r_wr_ptr;
  logic [c_aw-1:0]        r_rd_ptr;
  logic [c_cw-1:0]        r_count;
  logic                   r_merged;

  logic                   w_pop;
  logic                   w_can_grant;
  logic                   w_grant_valid;
  logic [c_idx_w-1:0]     w_grant_idx;
  logic [c_idx_w:0]       w_scan;
  logic                   w_push;
  logic [NUM_NEURONS-1:0] w_grant_mask;
  logic [c_idx_w:0]       w_rr_inc;
  logic [c_idx_w-1:0]     w_next_rr;
  logic [11:0]            w_grant_addr;

  function automatic logic [c_aw-1:0] ptr_inc(input logic [c_aw-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  assign addr_valid     = (r_count != '0);
  assign fifo_full      = (r_count == c_depth);
  assign spike_merged   = r_merged;
  assign source_address = addr_valid ? r_mem[r_rd_ptr] : 12'd0;

  assign w_pop       = addr_valid & addr_ready;
  // A pop frees a slot at the same edge, so a full FIFO can still accept a grant.
  assign w_can_grant = ~fifo_full | w_pop;
  assign w_push      = w_grant_valid & w_can_grant;

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_scan        = '0;
    for (int j = 0; j < NUM_NEURONS; j++) begin
      w_scan = {1'b0, r_rr_ptr} + (c_idx_w + 1)'(j);
      if (w_scan >= c_num) begin
        w_scan = w_scan - c_num;
      end
      if (!w_grant_valid && r_pending[w_scan[c_idx_w-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_scan[c_idx_w-1:0];
      end
    end
  end

  always_comb begin
    w_grant_mask = '0;
    if (w_push) begin
      w_grant_mask[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    w_rr_inc  = {1'b0, w_grant_idx} + 1'b1;
    w_next_rr = (w_rr_inc == c_num) ? '0 : w_rr_inc[c_idx_w-1:0];
  end

  assign w_grant_addr = BASE_ADDR + 12'(w_grant_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_merged  <= 1'b0;
    end else begin
      // A new spike on the granted bit re-arms it as a fresh event.
      r_pending <= (r_pending & ~w_grant_mask) | spike_in;
      if (|(spike_in & r_pending & ~w_grant_mask)) begin
        r_merged <= 1'b1;
      end
      if (w_push) begin
        r_rr_ptr <= w_next_rr;
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; its contents are masked while occupancy is zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_grant_addr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spike_packetizer.sv
// +--------------------------------------------------------------------------+
// | tb_spike_packetizer: directed plus random stimulus against a queue model. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_spike_packetizer;

  localparam int N     = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] spike_in;
  logic        addr_ready;
  logic [11:0] source_address;
  logic        addr_valid;
  logic        fifo_full;
  logic        spike_merged;

  spike_packetizer #(
    .NUM_NEURONS(N),
    .BASE_ADDR  (12'd1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .spike_in      (spike_in),
    .source_address(source_address),
    .addr_valid    (addr_valid),
    .addr_ready    (addr_ready),
    .fifo_full     (fifo_full),
    .spike_merged  (spike_merged)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: set of pending neurons, a rotating start point and a queue of addresses.
  bit [15:0] m_pend;
  int        m_rr;
  int        m_q[$];
  bit        m_merged;
  int        popped[$];

  function automatic void m_reset();
    m_pend   = '0;
    m_rr     = 0;
    m_q.delete();
    m_merged = 1'b0;
  endfunction

  function automatic void m_edge(bit [15:0] sp, bit rdy);
    bit        pop;
    int        g;
    bit [15:0] old;
    bit [15:0] gmask;
    pop = (m_q.size() > 0) && rdy;
    g   = -1;
    if (m_q.size() < DEPTH || pop) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    old   = m_pend;
    gmask = '0;
    if (pop) popped.push_back(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g + 1);
      m_pend[g] = 1'b0;
      gmask[g]  = 1'b1;
      m_rr      = (g + 1) % N;
    end
    if ((sp & old & ~gmask) != 16'h0) m_merged = 1'b1;
    m_pend = m_pend | sp;
  endfunction

  task automatic check_outputs();
    chk("addr_valid", addr_valid, (m_q.size() > 0));
    chk("source_address", source_address, (m_q.size() > 0) ? m_q[0] : 0);
    chk("fifo_full", fifo_full, (m_q.size() == DEPTH));
    chk("spike_merged", spike_merged, m_merged);
  endtask

  task automatic cycle(input logic [15:0] sp, input logic rdy);
    spike_in   = sp;
    addr_ready = rdy;
    @(posedge clk);
    m_edge(sp, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    spike_in   = 16'hFFFF;
    addr_ready = 1'b1;
    #1;
    m_reset();
    check_outputs();
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
    rst      = 1'b0;
    spike_in = '0;
  endtask

  task automatic chk_popped(input string tag, input int exp[$]);
    chk({tag, "_count"}, popped.size(), exp.size());
    for (int i = 0; i < exp.size() && i < popped.size(); i++) begin
      chk(tag, popped[i], exp[i]);
    end
  endtask

  initial begin
    int          exp[$];
    logic [15:0] sp;
    logic        rdy;

    rst        = 1'b1;
    spike_in   = '0;
    addr_ready = 1'b0;
    m_reset();
    @(negedge clk);
    do_reset();

    // Single spike on neuron 6.
    popped.delete();
    cycle(16'h0040, 1'b1);
    cycle(16'h0000, 1'b1);
    chk("single_addr", source_address, 12'd7);
    cycle(16'h0000, 1'b1);
    chk("single_idle", source_address, 12'd0);
    repeat (2) cycle(16'h0000, 1'b1);
    exp = {7};
    chk_popped("single_seq", exp);

    // Simultaneous spikes on 0, 3, 15.
    do_reset();
    popped.delete();
    cycle(16'h8009, 1'b1);
    repeat (6) cycle(16'h0000, 1'b1);
    exp = {1, 4, 16};
    chk_popped("multi_seq", exp);

    // Fairness with two neurons firing continuously.
    do_reset();
    popped.delete();
    repeat (12) cycle(16'h0024, 1'b1);
    repeat (4) cycle(16'h0000, 1'b1);
    chk("fair_merged", spike_merged, 1'b1);
    exp = {3, 6, 3, 6};
    for (int i = 0; i < 4; i++) chk("fair_seq", (i < popped.size()) ? popped[i] : -1, exp[i]);

    // Backpressure: all neurons fire once with the consumer stalled.
    do_reset();
    popped.delete();
    cycle(16'hFFFF, 1'b0);
    repeat (8) cycle(16'h0000, 1'b0);
    chk("bp_full", fifo_full, 1'b1);
    repeat (3) cycle(16'h0000, 1'b0);
    repeat (24) cycle(16'h0000, 1'b1);
    exp.delete();
    for (int i = 1; i <= 16; i++) exp.push_back(i);
    chk_popped("bp_seq", exp);

    // Reset in the middle of a stream.
    do_reset();
    cycle(16'h001F, 1'b0);
    repeat (5) cycle(16'h0000, 1'b0);
    chk("mr_queued_valid", addr_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", addr_valid, 1'b0);
    chk("mr_addr", source_address, 12'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    popped.delete();
    cycle(16'h0001, 1'b1);
    repeat (3) cycle(16'h0000, 1'b1);
    exp = {1};
    chk_popped("mr_seq", exp);

    // Random traffic with bursts of backpressure and occasional reset.
    do_reset();
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 3))
          0:       sp = 16'($urandom);
          1:       sp = 16'(1) << $urandom_range(0, 15);
          default: sp = '0;
        endcase
        rdy = ((t / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        cycle(sp, rdy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spike_packetizer.md
SPIKE_PACKETIZER -- requirements
Module: spike_packetizer

Interface
REQ-001 Parameter NUM_NEURONS, default 16: number of local neuron spike inputs, 2..64.
REQ-002 Parameter BASE_ADDR, default 12'd1: address assigned to spike_in[0]; SHALL be nonzero.
REQ-003 Parameter FIFO_DEPTH, default 8: output queue entries, power of two.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 spike_in  input  NUM_NEURONS  per-neuron spike pulse; bit i high at a rising edge = one spike event from neuron i.
REQ-007 source_address  output  12  address of the queued spike at the FIFO head; 12'd0 when addr_valid is low.
REQ-008 addr_valid  output  1  source_address holds a valid spike address.
REQ-009 addr_ready  input  1  consumer accepts source_address on a rising edge when addr_valid and addr_ready are both high.
REQ-010 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 spike_merged  output  1  sticky; set when a spike arrives on a bit that is already pending and not granted that cycle.

Function
REQ-012 Address of neuron i SHALL be BASE_ADDR + i, truncated to 12 bits; address 12'd0 is reserved as "no spike".
REQ-013 A pending register (NUM_NEURONS bits) SHALL set bit i at an edge where spike_in[i] is high.
REQ-014 A round-robin arbiter SHALL grant at most one pending bit per cycle, searching from rr_ptr upward with wrap at NUM_NEURONS.
REQ-015 After a grant to index g, rr_ptr SHALL become (g+1) mod NUM_NEURONS; with no grant, rr_ptr holds.
REQ-016 A grant SHALL occur only when the FIFO is not full, or when a pop occurs in the same cycle; the granted address is written to the FIFO at that edge.
REQ-017 Granted pending bit SHALL clear at the grant edge, except when spike_in for that bit is high at the same edge, in which case it stays set as a new event.
REQ-018 A spike on a pending bit that is not granted that edge SHALL merge (no duplicate entry) and set spike_merged.
REQ-019 Latency: spike sampled at edge k SHALL, with an empty FIFO and no competing pending bits, produce addr_valid high after edge k+1.
REQ-020 FIFO SHALL be show-ahead: source_address reflects the head entry combinationally from stored state whenever addr_valid is high.
REQ-021 Pop SHALL occur exactly at edges with addr_valid and addr_ready high; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-022 Entries SHALL leave the FIFO in write order; no spike event SHALL be lost except by merge (REQ-018).
REQ-023 fifo_full and addr_valid SHALL derive from registered occupancy (0..FIFO_DEPTH); occupancy SHALL never exceed FIFO_DEPTH nor underflow.
REQ-024 Backpressure: while addr_ready is low and FIFO full, pending bits SHALL hold and continue accepting spikes (merging per REQ-018).

Reset
REQ-025 While rst is high: pending=0, rr_ptr=0, FIFO occupancy=0, read/write pointers=0, spike_merged=0, addr_valid=0, fifo_full=0, source_address=12'd0.
REQ-026 rst asserted mid-operation SHALL discard all queued and pending spikes immediately, with no output glitch to a nonzero address.
REQ-027 spike_in sampled at the first edge after rst deasserts SHALL be captured normally.

Verification (NUM_NEURONS=16, BASE_ADDR=1, FIFO_DEPTH=8)
REQ-028 Reset: rst=1 with spike_in=16'hFFFF -> source_address=0, addr_valid=0, fifo_full=0, spike_merged=0 throughout.
REQ-029 Single spike: spike_in[6] pulsed at edge k, addr_ready=1 -> addr_valid=1 and source_address=12'd7 after edge k+1, popped at edge k+2, then source_address=0.
REQ-030 Simultaneous spikes on bits 0,3,15, addr_ready=1 -> addresses 1, 4, 16 on three consecutive cycles, no others.
REQ-031 Fairness: spike_in[2] and spike_in[5] held high continuously -> output alternates 3, 6, 3, 6; spike_merged sets.
REQ-032 Backpressure: addr_ready=0, spike_in=16'hFFFF for one edge -> fifo_full=1 after 8 grants, 8 bits remain pending; addr_ready=1 -> addresses 1..16 in order, each exactly once.
REQ-033 Reset mid-stream: 5 entries queued, rst pulsed -> addr_valid=0 immediately; new spike_in[0] after release -> single address 1.
